cp_arbiter: RTL and testbench
=============================

// Module: cp_arbiter
// PURPOSE
//  Complete-stage arbiter between the execute FUs (ALU, mult_fu, load, branch) and the single CDB.
//  Buffers each FU's EX_CP_PACKET in a per-FU FIFO and grants one packet per cycle, round-robin.
//  Drives the registered CDB/complete packet and per-FU stall credits back to issue.
//  Exists because mult_fu and the other FUs have fixed latency and cannot stall internally.
// PARAMETERS
//  NUM_FU  4  number of FU input ports (port 0 = highest priority after reset)
//  DEPTH   8  entries per FU FIFO; power of 2, >= SLACK+1
//  SLACK   4  max ops in flight inside any FU (mult_fu NUM_STAGE); sets the stall threshold
// PORTS
//  clock            in   1                    system clock, rising edge
//  reset            in   1                    asynchronous, active-low; 0 = in reset
//  squash_in        in   1                    branch-mispredict flush
//  ex_cp_packet_in  in   EX_CP_PACKET[NUM_FU]  FU results; entry is present when its .valid = 1
//  fu_stall_out     out  NUM_FU               1 = issue must not send new ops to FU i
//  cp_packet_out    out  EX_CP_PACKET         registered CDB broadcast; .valid marks a real packet
//  cp_grant_out     out  NUM_FU               one-hot source FU of cp_packet_out; 0 when not valid
//  overflow_err     out  1                    sticky; a packet arrived at a full FIFO
// BEHAVIOUR
//  Reset (reset = 0, asynchronous)
//   - All FIFO pointers and counts = 0.
//   - cp_packet_out = all zero (.valid = 0); cp_grant_out = 0; fu_stall_out = 0; overflow_err = 0.
//   - Round-robin pointer rr = 0.
//   - Reset asserted mid-operation discards all buffered packets immediately.
//  Enqueue
//   - At a rising edge, ex_cp_packet_in[i] with .valid = 1 is written to FIFO i.
//   - Accepted when count_i < DEPTH, or when FIFO i is dequeued in the same cycle.
//   - Otherwise the packet is dropped and overflow_err is set to 1; it stays 1 until reset.
//   - Inputs with .valid = 0 are ignored; all other fields are don't-care.
//  Arbitration (combinational on FIFO heads, registered output)
//   - Candidate set = FIFOs with count > 0.
//   - Grant goes to the first candidate found searching from index rr upward, with wrap (NUM_FU-1 -> 0).
//   - At the edge: cp_packet_out <= head of the granted FIFO (.valid = 1) and cp_grant_out <= one-hot(g).
//     The head is popped and rr <= (g+1) mod NUM_FU.
//   - No candidates: cp_packet_out.valid <= 0, cp_grant_out <= 0, rr unchanged.
//   - No bypass. A packet presented in cycle t to an empty FIFO appears on cp_packet_out in cycle t+2 at the earliest.
//   - Exactly one packet per cycle max; ordering within one FU is strictly FIFO.
//  Stall credit
//   - fu_stall_out[i] is registered and equals (next count_i >= DEPTH-SLACK).
//   - This guarantees the FU's in-flight ops always fit in FIFO i.
//  Squash (squash_in = 1 at an edge)
//   - All FIFOs are emptied.
//   - Same-cycle inputs are discarded.
//   - cp_packet_out.valid <= 0, cp_grant_out <= 0, fu_stall_out <= 0.
//   - rr is unchanged and overflow_err is unchanged.
//   - Squash has priority over enqueue and dequeue.
//  Width/pointers
//   - Pointers are log2(DEPTH) bits and wrap naturally.
//   - Counts are log2(DEPTH)+1 bits, so full vs. empty is unambiguous.
// TESTING
//  1 Reset: reset = 0 with random inputs -> all outputs 0; release, idle 3 cycles -> cp_packet_out.valid stays 0.
//  2 Latency: FU1 sends one packet, Value = 32'hdeadbeef, at cycle t -> cp_packet_out.Value = 32'hdeadbeef, grant = 4'b0010 at cycle t+2, then valid = 0.
//  3 Round-robin: all 4 FUs send 1 packet each in the same cycle -> grants 0001, 0010, 0100, 1000 on 4 consecutive cycles.
//    Then FU0 and FU2 each send one packet -> FU0 first (rr back at 0), then FU2.
//  4 Fill: FU3 sends every cycle while FU0 also sends every cycle -> fu_stall_out[3] = 1 once count_3 >= 4.
//    FU keeps sending the 4 in-flight packets -> none lost, overflow_err = 0; all drained in order.
//  5 Overflow: ignore stall and send 10 packets to FU2 with other FIFOs kept busy -> overflow_err = 1.
//    Exactly the accepted packets appear, in order.
//  6 Squash / mid-op reset: 3 packets buffered, squash_in = 1 for 1 cycle -> no further valid output, counts 0.
//    Repeat with reset = 0 mid-drain -> outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/cp_arbiter.sv
// cp_arbiter: complete-stage arbiter. Buffers each FU's result in a private FIFO
// and sends one packet per cycle to the CDB, round-robin across FUs.
// Stall credits tell issue when a FIFO can no longer absorb the FU's in-flight ops.

package cp_arbiter_pkg;
    localparam int unsigned VALUE_W = 32;
    localparam int unsigned TAG_W   = 6;

    typedef struct packed {
        logic               valid;
        logic [TAG_W-1:0]   tag;
        logic [VALUE_W-1:0] Value;
    } ex_cp_packet_t;
endpackage

module cp_arbiter
    import cp_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SLACK  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash_in,
    input  ex_cp_packet_t       ex_cp_packet_in [NUM_FU],
    output logic [NUM_FU-1:0]   fu_stall_out,
    output ex_cp_packet_t       cp_packet_out,
    output logic [NUM_FU-1:0]   cp_grant_out,
    output logic                overflow_err
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned IDX_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned STALL_AT = DEPTH - SLACK;

    // FIFO storage and bookkeeping
    ex_cp_packet_t      mem_q    [NUM_FU][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_FU];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_FU];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_FU];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_FU];
    logic [CNT_W-1:0]   count_q  [NUM_FU];
    logic [CNT_W-1:0]   count_d  [NUM_FU];

    // Arbitration and output registers
    logic [IDX_W-1:0]   rr_q, rr_d;
    ex_cp_packet_t      cp_packet_q, cp_packet_d;
    logic [NUM_FU-1:0]  grant_q, grant_d;
    logic [NUM_FU-1:0]  stall_q, stall_d;
    logic               ovf_q, ovf_d;

    logic               found_c;
    logic [IDX_W-1:0]   gnt_idx_c;
    logic [NUM_FU-1:0]  deq_c;
    logic [NUM_FU-1:0]  enq_c;

    // Round-robin search: first non-empty FIFO at or after rr, wrapping
    always_comb begin
        logic [IDX_W:0] sum;
        found_c   = 1'b0;
        gnt_idx_c = '0;
        sum       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_FU)) begin
                sum = sum - (IDX_W+1)'(NUM_FU);
            end
            if (!found_c && (count_q[IDX_W'(sum)] != '0)) begin
                found_c   = 1'b1;
                gnt_idx_c = IDX_W'(sum);
            end
        end
    end

    // Decode the winning index into per-FIFO pop strobes
    always_comb begin
        deq_c = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            deq_c[i] = found_c && (gnt_idx_c == IDX_W'(i));
        end
    end

    // Next-state: grant/pop, enqueue with overflow detection, squash override
    always_comb begin
        rr_d        = rr_q;
        ovf_d       = ovf_q;
        cp_packet_d = '0;
        grant_d     = '0;
        stall_d     = '0;
        enq_c       = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            count_d[i]  = count_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
        end

        if (squash_in) begin
            // Flush wins over everything; rr and the sticky error are kept
            for (int i = 0; i < NUM_FU; i++) begin
                count_d[i]  = '0;
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end
        end else begin
            if (found_c) begin
                cp_packet_d          = mem_q[gnt_idx_c][rd_ptr_q[gnt_idx_c]];
                cp_packet_d.valid    = 1'b1;
                grant_d[gnt_idx_c]   = 1'b1;
                rr_d = (gnt_idx_c == IDX_W'(NUM_FU-1)) ? '0 : IDX_W'(gnt_idx_c + 1'b1);
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (ex_cp_packet_in[i].valid) begin
                    // A full FIFO still accepts when its head leaves this cycle
                    if ((count_q[i] < CNT_W'(DEPTH)) || deq_c[i]) begin
                        enq_c[i] = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (enq_c[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                if (deq_c[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                case ({enq_c[i], deq_c[i]})
                    2'b10:   count_d[i] = count_q[i] + 1'b1;
                    2'b01:   count_d[i] = count_q[i] - 1'b1;
                    default: count_d[i] = count_q[i];
                endcase
                stall_d[i] = (count_d[i] >= CNT_W'(STALL_AT));
            end
        end
    end

    // FIFO payload storage; contents are meaningless while the count is zero
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (enq_c[i]) begin
                mem_q[i][wr_ptr_q[i]] <= ex_cp_packet_in[i];
            end
        end
    end

    // State register; reset drops every buffered packet at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            rr_q        <= '0;
            cp_packet_q <= '0;
            grant_q     <= '0;
            stall_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                count_q[i]  <= count_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            rr_q        <= rr_d;
            cp_packet_q <= cp_packet_d;
            grant_q     <= grant_d;
            stall_q     <= stall_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cp_packet_out = cp_packet_q;
    assign cp_grant_out  = grant_q;
    assign fu_stall_out  = stall_q;
    assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_cp_arbiter.sv
// tb_cp_arbiter: directed vector table plus a queue-based reference model for
// the multi-cycle fill, overflow, squash and asynchronous reset scenarios.

module tb_cp_arbiter;
    import cp_arbiter_pkg::*;

    localparam int unsigned NUM_FU = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SLACK  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          squash_in;
    ex_cp_packet_t pkt_in [NUM_FU];
    logic [3:0]    fu_stall_out;
    ex_cp_packet_t cp_packet_out;
    logic [3:0]    cp_grant_out;
    logic          overflow_err;

    cp_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clock           (clock),
        .reset           (reset),
        .squash_in       (squash_in),
        .ex_cp_packet_in (pkt_in),
        .fu_stall_out    (fu_stall_out),
        .cp_packet_out   (cp_packet_out),
        .cp_grant_out    (cp_grant_out),
        .overflow_err    (overflow_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        valid;
        logic [3:0]  grant;
        logic [31:0] value;
        logic [3:0]  stall;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0]       vld;
        logic [3:0][31:0] vals;
        logic             exp_valid;
        logic [3:0]       exp_grant;
        logic [31:0]      exp_value;
    } vec_t;

    exp_t        sbq [$];
    logic [31:0] mq [NUM_FU][$];
    int unsigned mrr;
    logic        movf;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  last_stall = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        mrr  = 0;
        movf = 1'b0;
        sbq.delete();
    endtask

    function automatic int mtotal();
        int t = 0;
        for (int i = 0; i < NUM_FU; i++) t += mq[i].size();
        return t;
    endfunction

    // Behavioural reference: what the registered outputs hold after this edge
    task automatic model_step(input logic [3:0] vld, input logic [3:0][31:0] vals,
                              input logic sq, output exp_t e);
        bit found = 0;
        int g = 0;
        e = '0;
        if (sq) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            e.ovf = movf;
            return;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            int idx = int'((mrr + 32'(k)) % NUM_FU);
            if (!found && mq[idx].size() > 0) begin
                found = 1;
                g = idx;
            end
        end
        if (found) begin
            e.valid    = 1'b1;
            e.grant[g] = 1'b1;
            e.value    = mq[g].pop_front();
            mrr        = (32'(g) + 1) % NUM_FU;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (vld[i]) begin
                if (mq[i].size() < int'(DEPTH)) mq[i].push_back(vals[i]);
                else movf = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FU; i++) e.stall[i] = (mq[i].size() >= int'(DEPTH - SLACK));
        e.ovf = movf;
    endtask

    // One clock: drive, push the expectation, pop and compare after the edge
    task automatic cycle(input logic [3:0] vld, input logic [3:0][31:0] vals, input logic sq,
                         input bit use_tab, input logic tv, input logic [3:0] tg,
                         input logic [31:0] tval);
        exp_t e;
        exp_t got;
        for (int i = 0; i < NUM_FU; i++) begin
            pkt_in[i].valid = vld[i];
            pkt_in[i].tag   = 6'(i);
            pkt_in[i].Value = vals[i];
        end
        squash_in = sq;
        model_step(vld, vals, sq, e);
        if (use_tab) begin
            e.valid = tv;
            e.grant = tg;
            e.value = tval;
        end
        sbq.push_back(e);
        @(posedge clock);
        #1;
        got = sbq.pop_front();
        check("out_valid", 32'(cp_packet_out.valid), 32'(got.valid));
        check("grant", 32'(cp_grant_out), 32'(got.grant));
        if (got.valid) check("value", cp_packet_out.Value, got.value);
        check("stall", 32'(fu_stall_out), 32'(got.stall));
        check("overflow", 32'(overflow_err), 32'(got.ovf));
        last_stall = fu_stall_out;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(4'b0, '0, 1'b0, 1'b0, 1'b0, 4'b0, 32'h0);
    endtask

    task automatic drain();
        int guard = 0;
        while (mtotal() > 0 && guard < 64) begin
            idle(1);
            guard++;
        end
        check("drain_bound", 32'(guard < 64), 32'd1);
        idle(1);
    endtask

    function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] v3, input logic [31:0] v2,
                                input logic [31:0] v1, input logic [31:0] v0, input logic ev,
                                input logic [3:0] eg, input logic [31:0] eval);
        vec_t r;
        r.vld       = vld;
        r.vals      = {v3, v2, v1, v0};
        r.exp_valid = ev;
        r.exp_grant = eg;
        r.exp_value = eval;
        return r;
    endfunction

    vec_t tab [11];

    initial begin
        logic [3:0]       vld;
        logic [3:0][31:0] vals;
        int               ex   [NUM_FU];
        bit               done [NUM_FU];
        bit               saw3;

        // Round-robin rows (fresh rr = 0), then single-packet latency rows
        tab[0]  = mk(4'b1111, 32'hA3, 32'hA2, 32'hA1, 32'hA0, 1'b0, 4'b0000, 32'h0);
        tab[1]  = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0001, 32'hA0);
        tab[2]  = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0010, 32'hA1);
        tab[3]  = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0100, 32'hA2);
        tab[4]  = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b1000, 32'hA3);
        tab[5]  = mk(4'b0101, 32'h0,  32'hB2, 32'h0,  32'hB0, 1'b0, 4'b0000, 32'h0);
        tab[6]  = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0001, 32'hB0);
        tab[7]  = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0100, 32'hB2);
        tab[8]  = mk(4'b0010, 32'h0,  32'h0,  32'hdeadbeef, 32'h0, 1'b0, 4'b0000, 32'h0);
        tab[9]  = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 4'b0010, 32'hdeadbeef);
        tab[10] = mk(4'b0000, 32'h0,  32'h0,  32'h0,  32'h0,  1'b0, 4'b0000, 32'h0);

        // Reset held with random inputs: outputs must stay zero
        reset     = 1'b0;
        squash_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                pkt_in[i].valid = 1'($urandom_range(1, 0));
                pkt_in[i].tag   = 6'($urandom);
                pkt_in[i].Value = $urandom;
            end
            squash_in = 1'($urandom_range(1, 0));
            @(posedge clock);
            #1;
            check("rst_valid", 32'(cp_packet_out.valid), 32'd0);
            check("rst_grant", 32'(cp_grant_out), 32'd0);
            check("rst_stall", 32'(fu_stall_out), 32'd0);
            check("rst_ovf", 32'(overflow_err), 32'd0);
        end
        reset = 1'b1;
        model_reset();
        idle(3);

        // Table vectors
        for (int r = 0; r < 11; r++) begin
            cycle(tab[r].vld, tab[r].vals, 1'b0, 1'b1, tab[r].exp_valid, tab[r].exp_grant,
                  tab[r].exp_value);
        end

        // Fill: FU0 and FU3 stream, each honouring stall after 4 more in-flight packets
        saw3 = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            ex[i]   = 0;
            done[i] = (i == 1 || i == 2);
        end
        for (int c = 0; c < 40 && !(done[0] && done[3]); c++) begin
            vld  = '0;
            vals = '0;
            if (last_stall[3]) saw3 = 1;
            for (int f = 0; f < NUM_FU; f++) begin
                if (!done[f]) begin
                    vld[f]  = 1'b1;
                    vals[f] = 32'h3000_0000 + 32'(f << 8) + 32'(c);
                    if (last_stall[f] || ex[f] > 0) begin
                        ex[f]++;
                        if (ex[f] == 4) done[f] = 1;
                    end
                end
            end
            cycle(vld, vals, 1'b0, 1'b0, 1'b0, 4'b0, 32'h0);
        end
        check("fill_stall3_seen", 32'(saw3), 32'd1);
        check("fill_no_overflow", 32'(overflow_err), 32'd0);
        drain();

        // Overflow: FU2 gets 10 packets while the other FIFOs are flooded
        for (int c = 0; c < 12; c++) begin
            vld = 4'b1011;
            if (c >= 2) vld[2] = 1'b1;
            for (int f = 0; f < NUM_FU; f++) vals[f] = 32'h5000_0000 + 32'(f << 8) + 32'(c);
            cycle(vld, vals, 1'b0, 1'b0, 1'b0, 4'b0, 32'h0);
        end
        check("ovf_set", 32'(overflow_err), 32'd1);
        drain();

        // Squash with 3 buffered packets and a same-cycle input
        cycle(4'b0111, {32'h0, 32'h62, 32'h61, 32'h60}, 1'b0, 1'b0, 1'b0, 4'b0, 32'h0);
        cycle(4'b1000, {32'h63, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b0, 1'b0, 4'b0, 32'h0);
        idle(3);
        check("squash_keeps_ovf", 32'(overflow_err), 32'd1);

        // Asynchronous reset in the middle of a drain
        cycle(4'b1111, {32'h73, 32'h72, 32'h71, 32'h70}, 1'b0, 1'b0, 1'b0, 4'b0, 32'h0);
        idle(1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(cp_packet_out.valid), 32'd0);
        check("arst_grant", 32'(cp_grant_out), 32'd0);
        check("arst_stall", 32'(fu_stall_out), 32'd0);
        check("arst_ovf", 32'(overflow_err), 32'd0);
        for (int i = 0; i < NUM_FU; i++) pkt_in[i] = '0;
        squash_in = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
